// File: rtl/game_pkg.sv
// Shared definitions for the guessing-game display path: digit codes,
// anode patterns, segment constants and the scan FSM state type.
package game_pkg;

  typedef logic [4:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 5'd0;
  localparam digit_code_t CODE_HEX0  = 5'd1;
  localparam digit_code_t CODE_P     = 5'd17;
  localparam digit_code_t CODE_L     = 5'd18;
  localparam digit_code_t CODE_H     = 5'd19;

  // Anode enables are active-low; one digit lit per slot.
  localparam logic [3:0] AN_OFF   = 4'b1111;
  localparam logic [3:0] AN_SLOT0 = 4'b1110;
  localparam logic [3:0] AN_SLOT1 = 4'b1101;
  localparam logic [3:0] AN_SLOT2 = 4'b1011;
  localparam logic [3:0] AN_SLOT3 = 4'b0111;

  // Segment patterns {a,b,c,d,e,f,g}, active-low.
  localparam logic [6:0] SEG_OFF  = 7'b1111111;
  localparam logic [6:0] SEG_DASH = 7'b1111110;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_t;

  // Anode pattern that lights the digit belonging to a slot.
  function automatic logic [3:0] anode_for_slot(input logic [1:0] slot);
    logic [3:0] pattern;
    case (slot)
      2'd0:    pattern = AN_SLOT0;
      2'd1:    pattern = AN_SLOT1;
      2'd2:    pattern = AN_SLOT2;
      default: pattern = AN_SLOT3;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg_decode.sv
// Combinational digit-code to seven-segment pattern decoder.
// Codes above the defined set all render as a dash.
module seg_decode
  import game_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  // Map each game digit code to its active-low segment pattern.
  always_comb begin
    seg = SEG_DASH;
    case (code)
      CODE_BLANK: seg = SEG_OFF;
      CODE_HEX0:  seg = 7'b0000001;
      5'd2:       seg = 7'b1001111;
      5'd3:       seg = 7'b0010010;
      5'd4:       seg = 7'b0000110;
      5'd5:       seg = 7'b1001100;
      5'd6:       seg = 7'b0100100;
      5'd7:       seg = 7'b0100000;
      5'd8:       seg = 7'b0001111;
      5'd9:       seg = 7'b0000000;
      5'd10:      seg = 7'b0001100;
      5'd11:      seg = 7'b0001000;
      5'd12:      seg = 7'b1100000;
      5'd13:      seg = 7'b0110001;
      5'd14:      seg = 7'b1000010;
      5'd15:      seg = 7'b0110000;
      5'd16:      seg = 7'b0111000;
      CODE_P:     seg = 7'b0011000;
      CODE_L:     seg = 7'b1110001;
      CODE_H:     seg = 7'b1001000;
      default:    seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for the 4-digit common-anode display.
// Each slot starts with a short all-anodes-off window to stop ghosting;
// the digit inputs are snapshotted once per frame so a frame never mixes
// old and new values. A frame-granular blink blanks the anodes after a win.
// Outputs are registered and computed from the state being entered, so the
// visible outputs always match the slot/counter of the current cycle.
module seg_scan_driver
  import game_pkg::*;
#(
  parameter int CLK_DIV      = 140000,
  parameter int BLANK_CYCLES = 64,
  parameter int BLINK_FRAMES = 114
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] digit1,
  input  logic [4:0] digit2,
  input  logic [4:0] digit3,
  input  logic [4:0] digit4,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);
  localparam logic [7:0]       BLINK_LAST = 8'(BLINK_FRAMES);

  logic             started;
  logic [1:0]       slot_idx;
  logic [CNT_W-1:0] slot_cnt;
  scan_state_t      state;
  logic [7:0]       blink_cnt;
  logic             blink_on;
  digit_code_t      snap [4];

  logic [1:0]       next_slot;
  logic [CNT_W-1:0] next_cnt;
  logic             frame_start_next;
  scan_state_t      next_state;
  logic [7:0]       blink_cnt_next;
  logic             blink_on_next;
  logic [4:0]       shown_code;
  logic [6:0]       dec_seg;

  assign dp = 1'b1;

  // Slot position for the coming cycle; the first edge after reset only
  // arms the scanner so that cycle becomes counter 0 of slot 0.
  always_comb begin
    next_slot = slot_idx;
    next_cnt  = slot_cnt;
    if (!started) begin
      next_slot = 2'd0;
      next_cnt  = '0;
    end else if (slot_cnt == CNT_LAST) begin
      next_cnt  = '0;
      next_slot = (slot_idx == 2'd3) ? 2'd0 : slot_idx + 2'd1;
    end else begin
      next_cnt = slot_cnt + 1'b1;
    end
  end

  assign frame_start_next = (next_slot == 2'd0) && (next_cnt == '0);

  // BLANK/DRIVE transition for the coming cycle.
  always_comb begin
    next_state = state;
    case (state)
      ST_BLANK: if (next_cnt >= BLANK_LIM) next_state = ST_DRIVE;
      ST_DRIVE: if (next_cnt < BLANK_LIM)  next_state = ST_BLANK;
      default:  next_state = ST_BLANK;
    endcase
  end

  // Blink bookkeeping: count frames while enabled and flip phase only as a
  // new frame begins; dropping the enable restores the display at once.
  always_comb begin
    blink_cnt_next = blink_cnt;
    blink_on_next  = blink_on;
    if (!blink_en) begin
      blink_cnt_next = 8'd0;
      blink_on_next  = 1'b1;
    end else if (frame_start_next && (blink_cnt == BLINK_LAST)) begin
      blink_cnt_next = 8'd0;
      blink_on_next  = ~blink_on;
    end else if (frame_tick) begin
      blink_cnt_next = blink_cnt + 8'd1;
    end
  end

  // At a frame start the snapshot is being reloaded, so show the live input.
  assign shown_code = frame_start_next ? digit1 : snap[next_slot];

  seg_decode u_decode (
    .code (shown_code),
    .seg  (dec_seg)
  );

  // Scan sequencer with registered segment, anode and frame outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      slot_idx   <= 2'd0;
      slot_cnt   <= '0;
      state      <= ST_BLANK;
      blink_cnt  <= 8'd0;
      blink_on   <= 1'b1;
      for (int i = 0; i < 4; i++) snap[i] <= CODE_BLANK;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      started    <= 1'b1;
      slot_idx   <= next_slot;
      slot_cnt   <= next_cnt;
      state      <= next_state;
      blink_cnt  <= blink_cnt_next;
      blink_on   <= blink_on_next;
      if (frame_start_next) begin
        snap[0] <= digit1;
        snap[1] <= digit2;
        snap[2] <= digit3;
        snap[3] <= digit4;
      end
      seg        <= dec_seg;
      an         <= ((next_state == ST_DRIVE) && blink_on_next) ?
                    anode_for_slot(next_slot) : AN_OFF;
      frame_tick <= frame_start_next;
    end
  end

endmodule
